// File: rtl/down_count_monitor.sv
// Consumer-side sequence checker for a 3-bit down-counter ({q3,q2,q1}).
// Locks after LOCK_CNT consecutive correct decrements, then flags breaks and counts 0->7 wraps.
module down_count_monitor #(
  parameter int unsigned LOCK_CNT = 4,
  parameter int unsigned ERR_W    = 8,
  parameter int unsigned WRAP_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample,
  input  logic              clr,
  input  logic              q1,
  input  logic              q2,
  input  logic              q3,
  output logic [2:0]        value,
  output logic              locked,
  output logic              err,
  output logic              wrap,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [WRAP_W-1:0] wrap_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    TRACK,
    LOCKED
  } state_t;

  localparam logic [3:0]        LOCK_C   = 4'(LOCK_CNT);
  localparam logic [ERR_W-1:0]  ERR_ONE  = ERR_W'(1);
  localparam logic [WRAP_W-1:0] WRAP_ONE = WRAP_W'(1);

  state_t            state_q, state_d;
  logic [2:0]        prev_q, prev_d;
  logic [3:0]        match_q, match_d;
  logic [3:0]        match_inc;
  logic [2:0]        v;
  logic [2:0]        exp_v;
  logic [2:0]        value_d;
  logic              err_d;
  logic              wrap_d;
  logic [ERR_W-1:0]  err_cnt_d;
  logic [WRAP_W-1:0] wrap_cnt_d;

  assign v         = {q3, q2, q1};
  // 3-bit subtraction gives the 0 -> 7 wrap for free.
  assign exp_v     = prev_q - 3'd1;
  assign match_inc = match_q + 4'd1;
  assign locked    = (state_q == LOCKED);

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    match_d = match_q;
    value_d = value;
    err_d   = 1'b0;
    wrap_d  = 1'b0;
    if (sample) begin
      prev_d  = v;
      value_d = v;
      case (state_q)
        IDLE: begin
          match_d = '0;
          state_d = TRACK;
        end
        TRACK: begin
          if (v == exp_v) begin
            match_d = match_inc;
            if (match_inc == LOCK_C) state_d = LOCKED;
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          if (v == exp_v) begin
            if (prev_q == 3'd0) wrap_d = 1'b1;
          end else begin
            err_d   = 1'b1;
            match_d = '0;
            state_d = TRACK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // clr takes priority over a same-edge increment; the pulses themselves are unaffected.
  always_comb begin
    err_cnt_d  = err_cnt;
    wrap_cnt_d = wrap_cnt;
    if (clr) begin
      err_cnt_d  = '0;
      wrap_cnt_d = '0;
    end else begin
      if (err_d && (err_cnt != '1)) err_cnt_d = err_cnt + ERR_ONE;
      if (wrap_d) wrap_cnt_d = wrap_cnt + WRAP_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      prev_q   <= '0;
      match_q  <= '0;
      value    <= '0;
      err      <= 1'b0;
      wrap     <= 1'b0;
      err_cnt  <= '0;
      wrap_cnt <= '0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      match_q  <= match_d;
      value    <= value_d;
      err      <= err_d;
      wrap     <= wrap_d;
      err_cnt  <= err_cnt_d;
      wrap_cnt <= wrap_cnt_d;
    end
  end

endmodule
